// File: rtl/layered_video_mux_if.sv
// Pixel-side bundle for the layered video mux: layer requests/colours, mask writes and mux results.
interface layered_video_mux_if #(
  parameter int NUM_LAYERS = 16,
  parameter int RGB_W      = 8
);
  localparam int IDX_W = $clog2(NUM_LAYERS);

  logic [NUM_LAYERS-1:0]       layerDR;
  logic [NUM_LAYERS*RGB_W-1:0] layerRGB;
  logic [RGB_W-1:0]            backGroundRGB;
  logic                        startOfFrame;
  logic                        maskWrEn;
  logic [NUM_LAYERS-1:0]       maskData;
  logic [RGB_W-1:0]            RGBOut;
  logic                        winnerValid;
  logic [IDX_W-1:0]            winnerIdx;
  logic [NUM_LAYERS-1:0]       overlapMask;
  logic [15:0]                 frameCount;

  modport master (
    output layerDR, layerRGB, backGroundRGB, startOfFrame, maskWrEn, maskData,
    input  RGBOut, winnerValid, winnerIdx, overlapMask, frameCount
  );

  modport slave (
    input  layerDR, layerRGB, backGroundRGB, startOfFrame, maskWrEn, maskData,
    output RGBOut, winnerValid, winnerIdx, overlapMask, frameCount
  );
endinterface

// File: rtl/layered_video_mux.sv
// N-layer priority video mux (layer 0 highest), 2-stage pipeline, frame-synchronous enable mask,
// winner index and per-frame overlap flags.
module layered_video_mux #(
  parameter int NUM_LAYERS = 16,
  parameter int RGB_W      = 8
) (
  input logic               clk,
  input logic               reset,
  layered_video_mux_if.slave vid
);
  localparam int IDX_W = $clog2(NUM_LAYERS);
  localparam logic [NUM_LAYERS-1:0] ONE = NUM_LAYERS'(1);

  logic [NUM_LAYERS-1:0]       activeMask, shadowMask, acc, effDR;
  logic                        shadowPending, ovl;
  logic [NUM_LAYERS-1:0]       s1DR;
  logic [NUM_LAYERS*RGB_W-1:0] s1RGB;
  logic [RGB_W-1:0]            s1BG, winRGB;
  logic [IDX_W-1:0]            winIdx;

  assign effDR = vid.layerDR & activeMask;
  // Two or more bits set <=> clearing the lowest set bit leaves something behind.
  assign ovl   = |(effDR & (effDR - ONE));

  // Mask only moves on a frame boundary; a write coincident with sof takes effect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      activeMask    <= '1;
      shadowMask    <= '1;
      shadowPending <= 1'b0;
    end else if (vid.maskWrEn && vid.startOfFrame) begin
      activeMask    <= vid.maskData;
      shadowMask    <= vid.maskData;
      shadowPending <= 1'b0;
    end else if (vid.maskWrEn) begin
      shadowMask    <= vid.maskData;
      shadowPending <= 1'b1;
    end else if (vid.startOfFrame && shadowPending) begin
      activeMask    <= shadowMask;
      shadowPending <= 1'b0;
    end
  end

  // Overlap accumulator; the sof pixel opens the new frame's accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc             <= '0;
      vid.overlapMask <= '0;
      vid.frameCount  <= '0;
    end else if (vid.startOfFrame) begin
      vid.overlapMask <= acc;
      acc             <= ovl ? effDR : '0;
      vid.frameCount  <= vid.frameCount + 16'd1;
    end else if (ovl) begin
      acc <= acc | effDR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1DR  <= '0;
      s1RGB <= '0;
      s1BG  <= '0;
    end else begin
      s1DR  <= effDR;
      s1RGB <= vid.layerRGB;
      s1BG  <= vid.backGroundRGB;
    end
  end

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    winIdx = '0;
    winRGB = s1BG;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1DR[i]) begin
        winIdx = IDX_W'(i);
        winRGB = s1RGB[i*RGB_W +: RGB_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid.RGBOut      <= '0;
      vid.winnerValid <= 1'b0;
      vid.winnerIdx   <= '0;
    end else begin
      vid.RGBOut      <= winRGB;
      vid.winnerValid <= |s1DR;
      vid.winnerIdx   <= winIdx;
    end
  end
endmodule
